// File: rtl/turbo_pkg.sv
// Shared constants, FSM encodings and the column-major address map used by
// the turbo interleaver and its ping-pong bit buffer.
package turbo_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int FRAME_LEN = ROWS * COLS;
  localparam int AW        = $clog2(FRAME_LEN);
  localparam int RB        = $clog2(ROWS);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_FILL  = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  // (k % ROWS) * COLS + k / ROWS; with power-of-two dimensions this is a
  // rotation of the counter bits: row index on top, column index below.
  function automatic logic [AW-1:0] il_addr(input logic [AW-1:0] k);
    return {k[RB-1:0], k[AW-1:RB]};
  endfunction

endpackage

// File: rtl/pp_bitbuf.sv
// Two FRAME_LEN x 1 bit banks with one write port, one asynchronous read port
// and a full flag per bank; the owning FSMs decide when flags change.
module pp_bitbuf
  import turbo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_data_i,
  input  logic          set_full_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_data_o,
  input  logic          clr_full_i,
  output logic [1:0]    full_o,
  output logic [1:0]    avail_o
);

  logic [FRAME_LEN-1:0] bank_q [2];
  logic [1:0]           full_q, full_d;
  logic [1:0]           clr_mask, set_mask;

  // NOTE: bank storage has no reset; every address of a bank is written
  // (data or pad) before its full flag is raised, so stale bits never leak.
  always_ff @(posedge clk) begin
    if (wr_en_i) bank_q[wr_bank_i][wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = bank_q[rd_bank_i][rd_addr_i];

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_full_i) clr_mask[rd_bank_i] = 1'b1;
    if (set_full_i) set_mask[wr_bank_i] = 1'b1;
  end

  // A bank freed by the drain side this cycle is already available to the fill side.
  assign avail_o = ~(full_q & ~clr_mask);
  assign full_d  = (full_q & ~clr_mask) | set_mask;
  assign full_o  = full_q;

  always_ff @(posedge clk) begin
    if (!rst) full_q <= '0;
    else      full_q <= full_d;
  end

endmodule

// File: rtl/turbo_interleaver.sv
// Row-write / column-read block interleaver between the nibble serializer and
// the second RSC encoder, double-buffered so one frame fills while another drains.
module turbo_interleaver
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_en,
  output logic out_bit,
  output logic out_en,
  output logic frame_sop,
  output logic overrun
);

  logic [0:0]    w_state_q, w_state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          pad_q, pad_d;
  logic          drop_q, drop_d;
  logic          fill_sel_q, fill_sel_d;
  logic [0:0]    rd_state_q, rd_state_d;
  logic [AW-1:0] k_q, k_d;
  logic          drain_sel_q, drain_sel_d;
  logic          out_bit_q, out_bit_d, out_en_q, out_en_d;
  logic          sop_q, sop_d, overrun_q, overrun_d;

  logic          wr_en, wr_data, set_full, clr_full, rd_data;
  logic [AW-1:0] rd_addr;
  logic [1:0]    full, avail;

  assign rd_addr = il_addr(k_q);

  pp_bitbuf u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_bank_i  (fill_sel_q),
    .wr_addr_i  (waddr_q),
    .wr_data_i  (wr_data),
    .set_full_i (set_full),
    .rd_bank_i  (drain_sel_q),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .clr_full_i (clr_full),
    .full_o     (full),
    .avail_o    (avail)
  );

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_d  = w_state_q;
    waddr_d    = waddr_q;
    pad_d      = pad_q;
    drop_d     = drop_q;
    fill_sel_d = fill_sel_q;
    overrun_d  = overrun_q;
    wr_en      = 1'b0;
    wr_data    = 1'b0;
    set_full   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (drop_q) begin
          if (!in_en) drop_d = 1'b0;
        end else if (in_en) begin
          if (avail[fill_sel_q]) begin
            wr_en     = 1'b1;
            wr_data   = in_bit;
            waddr_d   = AW'(1);
            w_state_d = W_FILL;
          end else begin
            drop_d    = 1'b1;
            overrun_d = 1'b1;
          end
        end
      end
      W_FILL: begin
        // Once in_en drops the rest of the frame is zero-padded, ignoring in_en.
        wr_en   = 1'b1;
        wr_data = in_bit & in_en & ~pad_q;
        if (waddr_q == LAST_ADDR) begin
          set_full   = 1'b1;
          fill_sel_d = ~fill_sel_q;
          waddr_d    = '0;
          pad_d      = 1'b0;
          w_state_d  = W_IDLE;
        end else begin
          waddr_d = waddr_q + 1'b1;
          pad_d   = pad_q | ~in_en;
        end
      end
    endcase
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    k_d         = k_q;
    drain_sel_d = drain_sel_q;
    clr_full    = 1'b0;
    out_en_d    = 1'b0;
    out_bit_d   = 1'b0;
    sop_d       = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (full[drain_sel_q]) begin
          rd_state_d = R_DRAIN;
          k_d        = '0;
        end
      end
      R_DRAIN: begin
        out_en_d  = 1'b1;
        out_bit_d = rd_data;
        sop_d     = (k_q == '0);
        if (k_q == LAST_ADDR) begin
          clr_full    = 1'b1;
          drain_sel_d = ~drain_sel_q;
          k_d         = '0;
          if (!full[~drain_sel_q]) rd_state_d = R_IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q   <= W_IDLE;
      waddr_q     <= '0;
      pad_q       <= 1'b0;
      drop_q      <= 1'b0;
      fill_sel_q  <= 1'b0;
      rd_state_q  <= R_IDLE;
      k_q         <= '0;
      drain_sel_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_en_q    <= 1'b0;
      sop_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      waddr_q     <= waddr_d;
      pad_q       <= pad_d;
      drop_q      <= drop_d;
      fill_sel_q  <= fill_sel_d;
      rd_state_q  <= rd_state_d;
      k_q         <= k_d;
      drain_sel_q <= drain_sel_d;
      out_bit_q   <= out_bit_d;
      out_en_q    <= out_en_d;
      sop_q       <= sop_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign out_en    = out_en_q;
  assign frame_sop = sop_q;
  assign overrun   = overrun_q;

endmodule
